// File: rtl/mlp_pkg.sv
// mlp_pkg: shared types and helpers for the mlp_stream perceptron engine.
//   state_t    : frame sequencing states
//   calc_w_a   : layer-1 accumulator width
//   calc_w_y   : layer-2 result width
//   calc_aw    : weight write address width
//   sm_mul     : sign/magnitude sample times signed weight
package mlp_pkg;

  typedef enum logic [1:0] {
    S_IN  = 2'd0,
    S_L2  = 2'd1,
    S_OUT = 2'd2
  } state_t;

  function automatic int unsigned calc_w_a(input int unsigned w_x, input int unsigned w_k,
                                           input int unsigned n1);
    return w_x + w_k + int'($clog2(n1)) + 1;
  endfunction

  function automatic int unsigned calc_w_y(input int unsigned w_a, input int unsigned w_k,
                                           input int unsigned n2);
    return w_a + w_k + int'($clog2(n2));
  endfunction

  function automatic int unsigned calc_aw(input int unsigned n1, input int unsigned n2);
    return int'($clog2(n1 * n2 + n2));
  endfunction

  // Product at 32 bits; callers truncate to their accumulator width.
  function automatic logic signed [31:0] sm_mul(input logic [31:0] mag, input logic neg,
                                                input logic signed [31:0] k);
    logic signed [31:0] prod;
    prod = $signed(mag) * k;
    return neg ? -prod : prod;
  endfunction

endpackage

// File: rtl/mlp_stream_if.sv
// mlp_stream_if: input beat stream, weight write port, result stream and status.
//   slave  : the engine side (mlp_stream)
//   master : the producer/consumer side
interface mlp_stream_if import mlp_pkg::*; #(
  parameter int unsigned N1  = 98,
  parameter int unsigned N2  = 20,
  parameter int unsigned P   = 7,
  parameter int unsigned W_X = 4,
  parameter int unsigned W_K = 4
);
  localparam int unsigned AW  = calc_aw(N1, N2);
  localparam int unsigned W_Y = calc_w_y(calc_w_a(W_X, W_K, N1), W_K, N2);

  logic                  s_valid;
  logic                  s_ready;
  logic [P*W_X-1:0]      s_mag;
  logic [P-1:0]          s_pol;
  logic                  w_en;
  logic [AW-1:0]         w_addr;
  logic signed [W_K-1:0] w_data;
  logic                  m_valid;
  logic                  m_ready;
  logic signed [W_Y-1:0] m_data;
  logic                  busy;

  modport slave (
    input  s_valid, s_mag, s_pol, w_en, w_addr, w_data, m_ready,
    output s_ready, m_valid, m_data, busy
  );

  modport master (
    output s_valid, s_mag, s_pol, w_en, w_addr, w_data, m_ready,
    input  s_ready, m_valid, m_data, busy
  );
endinterface

// File: rtl/mlp_l1_neuron.sv
// mlp_l1_neuron: one hidden neuron; holds K1[J][*] and accumulates h_J over the beats.
//   clk, rst    : clock, async active-high reset
//   i_mag/i_pol : current beat samples (P lanes)
//   i_beat      : beat index selecting the weight lanes
//   i_first     : first beat of a frame (overwrite instead of add)
//   i_acc_en    : beat accepted this cycle
//   i_wr_*      : K1 write strobe / global address / data
//   o_h         : accumulated h_J
module mlp_l1_neuron import mlp_pkg::*; #(
  parameter int unsigned N1  = 98,
  parameter int unsigned P   = 7,
  parameter int unsigned W_X = 4,
  parameter int unsigned W_K = 4,
  parameter int unsigned W_A = 16,
  parameter int unsigned AW  = 11,
  parameter int unsigned BW  = 4,
  parameter int unsigned J   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [P*W_X-1:0]      i_mag,
  input  logic [P-1:0]          i_pol,
  input  logic [BW-1:0]         i_beat,
  input  logic                  i_first,
  input  logic                  i_acc_en,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic signed [W_K-1:0] i_wr_data,
  output logic signed [W_A-1:0] o_h
);
  localparam int unsigned IW   = (N1 > 1) ? $clog2(N1) : 1;
  localparam int unsigned PW   = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned BASE = J * N1;

  logic signed [W_K-1:0] r_k [N1];
  logic signed [W_A-1:0] r_h;
  logic signed [W_A-1:0] w_prod [P];
  logic signed [W_A-1:0] w_sum;
  logic [31:0]           w_off;
  logic                  w_hit;

  // Addresses below BASE wrap to huge offsets and fail the range test.
  assign w_off = 32'(i_wr_addr) - 32'(BASE);
  assign w_hit = i_wr_en && (w_off < 32'(N1));

  // One multiplier per lane.
  for (genvar p = 0; p < int'(P); p++) begin : g_lane
    assign w_prod[p] = W_A'(sm_mul(32'(i_mag[p*W_X +: W_X]), i_pol[p],
                                   32'(r_k[IW'(int'(i_beat) * int'(P) + p)])));
  end

  // Beat sum of the lane products.
  always_comb begin
    w_sum = '0;
    for (int p = 0; p < int'(P); p++) begin
      w_sum = w_sum + w_prod[PW'(p)];
    end
  end

  // Weight storage and h accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k <= '{default: '0};
      r_h <= '0;
    end else begin
      if (w_hit) begin
        r_k[IW'(w_off)] <= i_wr_data;
      end
      if (i_acc_en) begin
        r_h <= i_first ? w_sum : r_h + w_sum;
      end
    end
  end

  assign o_h = r_h;
endmodule

// File: rtl/mlp_stream.sv
// mlp_stream: time-multiplexed two-layer perceptron (N1 inputs, N2 hidden, scalar out).
//   clk, rst : clock, async active-high reset
//   bus      : mlp_stream_if.slave (input beats, weight writes, result, busy)
module mlp_stream import mlp_pkg::*; #(
  parameter int unsigned N1  = 98,
  parameter int unsigned N2  = 20,
  parameter int unsigned P   = 7,
  parameter int unsigned W_X = 4,
  parameter int unsigned W_K = 4
) (
  input logic         clk,
  input logic         rst,
  mlp_stream_if.slave bus
);
  localparam int unsigned BEATS = N1 / P;
  localparam int unsigned W_A   = calc_w_a(W_X, W_K, N1);
  localparam int unsigned W_Y   = calc_w_y(W_A, W_K, N2);
  localparam int unsigned AW    = calc_aw(N1, N2);
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned JW    = (N2 > 1) ? $clog2(N2) : 1;

  state_t                r_state, w_next_state;
  logic [BW-1:0]         r_beat, w_beat_nxt;
  logic [JW-1:0]         r_j, w_j_nxt;
  logic signed [W_Y-1:0] r_acc2, w_acc2_nxt;
  logic signed [W_Y-1:0] r_m_data, w_m_data_nxt;
  logic                  r_m_valid, w_m_valid_nxt;
  logic                  r_s_ready, w_s_ready_nxt;
  logic                  r_busy, w_busy_nxt;
  logic signed [W_K-1:0] r_k2 [N2];

  logic signed [W_A-1:0] w_h [N2];
  logic signed [W_A-1:0] w_h_sel, w_relu;
  logic signed [W_Y-1:0] w_prod, w_acc2_sum;
  logic                  w_accept, w_first, w_last_beat, w_last_j;
  logic                  w_wr_ok, w_k1_wr, w_k2_wr;
  logic [31:0]           w_k2_off;

  assign w_accept    = (r_state == S_IN) && bus.s_valid && r_s_ready;
  assign w_first     = (r_beat == '0);
  assign w_last_beat = (r_beat == BW'(BEATS - 1));
  assign w_last_j    = (r_j == JW'(N2 - 1));

  // Writes land only between frames, and never on the cycle a frame starts.
  assign w_wr_ok  = bus.w_en && (r_state == S_IN) && w_first && !w_accept;
  assign w_k1_wr  = w_wr_ok && (32'(bus.w_addr) < 32'(N1 * N2));
  assign w_k2_off = 32'(bus.w_addr) - 32'(N1 * N2);
  assign w_k2_wr  = w_wr_ok && (w_k2_off < 32'(N2));

  for (genvar g = 0; g < int'(N2); g++) begin : g_l1
    mlp_l1_neuron #(
      .N1(N1), .P(P), .W_X(W_X), .W_K(W_K), .W_A(W_A), .AW(AW), .BW(BW), .J(g)
    ) u_neuron (
      .clk       (clk),
      .rst       (rst),
      .i_mag     (bus.s_mag),
      .i_pol     (bus.s_pol),
      .i_beat    (r_beat),
      .i_first   (w_first),
      .i_acc_en  (w_accept),
      .i_wr_en   (w_k1_wr),
      .i_wr_addr (bus.w_addr),
      .i_wr_data (bus.w_data),
      .o_h       (w_h[g])
    );
  end

  // Serial layer-2 MAC over hidden neuron r_j.
  assign w_h_sel    = w_h[r_j];
  assign w_relu     = w_h_sel[W_A-1] ? '0 : w_h_sel;
  assign w_prod     = W_Y'(r_k2[r_j]) * W_Y'(w_relu);
  assign w_acc2_sum = (r_j == '0) ? w_prod : r_acc2 + w_prod;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IN;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IN:    if (w_accept && w_last_beat) w_next_state = S_L2;
      S_L2:    if (w_last_j) w_next_state = S_OUT;
      S_OUT:   if (bus.m_ready) w_next_state = S_IN;
      default: w_next_state = S_IN;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_beat_nxt    = r_beat;
    w_j_nxt       = r_j;
    w_acc2_nxt    = r_acc2;
    w_m_data_nxt  = r_m_data;
    w_m_valid_nxt = 1'b0;
    w_busy_nxt    = r_busy;
    w_s_ready_nxt = (w_next_state == S_IN);
    case (r_state)
      S_IN: begin
        if (w_accept) begin
          w_busy_nxt = 1'b1;
          w_beat_nxt = w_last_beat ? '0 : r_beat + 1'b1;
        end
      end
      S_L2: begin
        w_acc2_nxt = w_acc2_sum;
        w_j_nxt    = r_j + 1'b1;
        if (w_last_j) begin
          w_j_nxt       = '0;
          w_m_data_nxt  = w_acc2_sum;
          w_m_valid_nxt = 1'b1;
        end
      end
      S_OUT: begin
        w_m_valid_nxt = !bus.m_ready;
        if (bus.m_ready) w_busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat    <= '0;
      r_j       <= '0;
      r_acc2    <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_beat    <= w_beat_nxt;
      r_j       <= w_j_nxt;
      r_acc2    <= w_acc2_nxt;
      r_m_data  <= w_m_data_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Layer-2 weight file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k2 <= '{default: '0};
    end else if (w_k2_wr) begin
      r_k2[JW'(w_k2_off)] <= bus.w_data;
    end
  end

  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.busy    = r_busy;
endmodule

// File: tb/tb_mlp_stream.sv
// tb_mlp_stream: self-checking bench for mlp_stream at default parameters.
module tb_mlp_stream;
  import mlp_pkg::*;

  localparam int N1    = 98;
  localparam int N2    = 20;
  localparam int P     = 7;
  localparam int W_X   = 4;
  localparam int W_K   = 4;
  localparam int BEATS = N1 / P;
  localparam int NK1   = N1 * N2;
  localparam int NW    = NK1 + N2;
  localparam int AW    = $clog2(NW);

  logic clk = 1'b0;
  logic rst = 1'b1;

  mlp_stream_if #(.N1(N1), .N2(N2), .P(P), .W_X(W_X), .W_K(W_K)) bus ();

  mlp_stream #(.N1(N1), .N2(N2), .P(P), .W_X(W_X), .W_K(W_K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference weights (as they should be inside the DUT) and the current frame.
  int             mk1 [N2][N1];
  int             mk2 [N2];
  logic [W_X-1:0] fmag [N1];
  logic           fpol [N1];

  typedef struct {
    int k1;
    int k2;
    int mag;
    bit pol;
    int exp;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // y = sum_j K2[j] * ReLU(sum_i K1[j][i] * x_i)
  function automatic int model_y();
    int y;
    int h;
    y = 0;
    for (int j = 0; j < N2; j++) begin
      h = 0;
      for (int i = 0; i < N1; i++)
        h += mk1[j][i] * (fpol[i] ? -int'(fmag[i]) : int'(fmag[i]));
      if (h > 0) y += mk2[j] * h;
    end
    return y;
  endfunction

  task automatic clear_model();
    for (int j = 0; j < N2; j++) begin
      mk2[j] = 0;
      for (int i = 0; i < N1; i++) mk1[j][i] = 0;
    end
  endtask

  // One-cycle write; 'apply' says whether the engine is expected to take it.
  task automatic write_w(input int addr, input int data, input bit apply);
    bus.w_en   = 1'b1;
    bus.w_addr = AW'(addr);
    bus.w_data = W_K'(data);
    @(negedge clk);
    bus.w_en = 1'b0;
    if (apply && addr < NK1)     mk1[addr / N1][addr % N1] = data;
    else if (apply && addr < NW) mk2[addr - NK1] = data;
  endtask

  task automatic load_uniform(input int k1v, input int k2v);
    for (int a = 0; a < NW; a++) write_w(a, (a < NK1) ? k1v : k2v, 1'b1);
  endtask

  task automatic load_random();
    for (int a = 0; a < NW; a++) write_w(a, int'($urandom_range(0, 15)) - 8, 1'b1);
  endtask

  task automatic fill_uniform(input int mag, input bit pol);
    for (int i = 0; i < N1; i++) begin
      fmag[i] = W_X'(mag);
      fpol[i] = pol;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N1; i++) begin
      fmag[i] = W_X'($urandom_range(0, 15));
      fpol[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (bus.s_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("s_ready_timeout", int'(bus.s_ready), 1);
  endtask

  // Sends beats b0..b1; each task call starts and ends just after a falling edge.
  task automatic send_beats(input int b0, input int b1, input bit gaps);
    logic [P*W_X-1:0] mv;
    logic [P-1:0]     pv;
    for (int b = b0; b <= b1; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        @(negedge clk);
      end
      mv = '0;
      pv = '0;
      for (int p = 0; p < P; p++) begin
        mv = mv | ((P*W_X)'(fmag[b*P + p]) << (p * W_X));
        pv = pv | (P'(fpol[b*P + p]) << p);
      end
      bus.s_valid = 1'b1;
      bus.s_mag   = mv;
      bus.s_pol   = pv;
      wait_ready();
      @(negedge clk);
      bus.w_en = 1'b0;
    end
    bus.s_valid = 1'b0;
  endtask

  // Waits for the result, optionally checks latency, holds off m_ready, then accepts.
  task automatic recv(input string name, input int exp, input int pre, input bit chk_lat,
                      input int hold);
    int t;
    logic signed [24:0] d;
    t = pre;
    while (bus.m_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_valid"}, int'(bus.m_valid), 1);
    if (chk_lat) chk({name, "_latency"}, t, N2);
    chk({name, "_data"}, int'(bus.m_data), exp);
    d = bus.m_data;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk({name, "_hold_flags"}, int'({bus.m_valid, bus.s_ready, bus.busy}), 5);
      chk({name, "_hold_data"}, int'(bus.m_data), int'(d));
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk({name, "_after_flags"}, int'({bus.m_valid, bus.s_ready, bus.busy}), 2);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.w_en    = 1'b0;
    bus.m_ready = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rst_flags", int'({bus.s_ready, bus.m_valid, bus.busy}), 0);
    chk("rst_m_data", int'(bus.m_data), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_release_s_ready", int'(bus.s_ready), 0);
    @(negedge clk);
    chk("post_rst_s_ready", int'(bus.s_ready), 1);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int pk1;
    int pk2;
    int exp;
    bus.s_valid = 1'b0;
    bus.s_mag   = '0;
    bus.s_pol   = '0;
    bus.w_en    = 1'b0;
    bus.w_addr  = '0;
    bus.w_data  = '0;
    bus.m_ready = 1'b0;

    vt[0] = '{k1:  1, k2:  1, mag: 15, pol: 1'b0, exp:   29400};
    vt[1] = '{k1:  1, k2:  1, mag: 15, pol: 1'b1, exp:       0};
    vt[2] = '{k1:  1, k2: -8, mag: 15, pol: 1'b0, exp: -235200};
    vt[3] = '{k1: -1, k2:  1, mag: 15, pol: 1'b1, exp:   29400};
    vt[4] = '{k1:  7, k2:  7, mag: 15, pol: 1'b0, exp: 1440600};
    vt[5] = '{k1: -8, k2: -8, mag: 15, pol: 1'b1, exp: -1881600};
    vt[6] = '{k1:  3, k2: -2, mag:  9, pol: 1'b0, exp: -105840};
    vt[7] = '{k1:  1, k2:  1, mag:  1, pol: 1'b0, exp:    1960};

    @(negedge clk);
    do_reset();

    // Uniform weight/sample vectors with closed-form results.
    pk1 = 0;
    pk2 = 0;
    for (int v = 0; v < 8; v++) begin
      if (vt[v].k1 != pk1 || vt[v].k2 != pk2) load_uniform(vt[v].k1, vt[v].k2);
      pk1 = vt[v].k1;
      pk2 = vt[v].k2;
      fill_uniform(vt[v].mag, vt[v].pol);
      send_beats(0, BEATS - 1, 1'b0);
      recv($sformatf("vec%0d", v), vt[v].exp, 0, 1'b1, 0);
    end

    // Backpressure, then a frame started right after the handshake.
    fill_uniform(15, 1'b0);
    send_beats(0, BEATS - 1, 1'b0);
    recv("bp", 29400, 0, 1'b1, 5);
    send_beats(0, BEATS - 1, 1'b0);
    recv("b2b", 29400, 0, 1'b1, 0);

    // Reset after 3 of 14 beats.
    send_beats(0, 2, 1'b0);
    chk("busy_mid_frame", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_flags", int'({bus.s_ready, bus.m_valid, bus.busy}), 0);
    chk("async_rst_m_data", int'(bus.m_data), 0);
    do_reset();
    send_beats(0, BEATS - 1, 1'b0);
    recv("rst_zero_weights", model_y(), 0, 1'b1, 0);
    load_uniform(1, 1);
    send_beats(0, BEATS - 1, 1'b0);
    recv("rst_reloaded", 29400, 0, 1'b1, 0);

    // K2[0] writes mid-frame and during layer 2 are dropped.
    send_beats(0, 4, 1'b0);
    write_w(NK1, 7, 1'b0);
    send_beats(5, BEATS - 1, 1'b0);
    write_w(NK1, 7, 1'b0);
    recv("k2_ignored", 29400, 1, 1'b1, 0);
    write_w(NK1, 7, 1'b1);
    // Write coincident with the first beat is dropped as well.
    bus.w_en   = 1'b1;
    bus.w_addr = AW'(NK1 + 1);
    bus.w_data = W_K'(-3);
    send_beats(0, BEATS - 1, 1'b0);
    recv("k2_applied", 38220, 0, 1'b1, 0);

    // Random weights and samples against the reference model.
    for (int r = 0; r < 3; r++) begin
      load_random();
      write_w(NW + r, 5, 1'b0);
      write_w((1 << AW) - 1, -4, 1'b0);
      for (int f = 0; f < 2; f++) begin
        fill_random();
        exp = model_y();
        send_beats(0, BEATS - 1, 1'b1);
        recv($sformatf("rand%0d_%0d", r, f), exp, 0, 1'b1, int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
